// File: rtl/ex_iter.sv
// Execute stage with a registered (EX/MEM) output: single-cycle ALU ops plus iterative MUL/DIVU/REMU.
// Define EX_DIV_EN to build the restoring divider; without it, DIVU/REMU finish in one cycle with result 0.
module ex_iter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [OP_W-1:0]   aluop_i,
  input  logic [DATA_W-1:0] reg0_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              we_i,
  output logic              valid_o,
  input  logic              stall_i,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              we_o,
  output logic              busy_o
);
  localparam int SH_W = $clog2(DATA_W);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_DIVU = OP_W'(12);
  localparam logic [OP_W-1:0] OP_REMU = OP_W'(13);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [SH_W-1:0]   r_cnt;
  logic [DATA_W-1:0] r_a, r_b, r_acc, r_res;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_we;

  logic              w_out_free, w_accept, w_is_iter, w_last, w_load_iter;
  logic [SH_W-1:0]   w_sh;
  logic [DATA_W-1:0] w_alu, w_mul_acc, w_final, w_iter_data;

  assign w_out_free = !valid_o || !stall_i;
  assign ready_o    = (r_state == S_IDLE) && w_out_free;
  assign w_accept   = valid_i && ready_o;
  assign busy_o     = (r_state != S_IDLE);
  assign w_last     = (r_cnt == SH_W'(DATA_W - 1));
  assign w_sh       = reg1_i[SH_W-1:0];

`ifdef EX_DIV_EN
  logic [OP_W-1:0]   r_op;
  logic [DATA_W:0]   w_rem_sh, w_diff;
  logic              w_div_ge;
  logic [DATA_W-1:0] w_rem_nxt, w_quo_nxt;

  assign w_is_iter = (aluop_i == OP_MUL) || (aluop_i == OP_DIVU) || (aluop_i == OP_REMU);

  // Restoring divide: r_acc is the partial remainder, r_a shifts the dividend out and quotient in.
  assign w_rem_sh  = {r_acc, r_a[DATA_W-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_div_ge  = !w_diff[DATA_W];
  assign w_rem_nxt = w_div_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
  assign w_quo_nxt = {r_a[DATA_W-2:0], w_div_ge};

  always_comb begin
    w_final = w_mul_acc;
    case (r_op)
      OP_DIVU: w_final = w_quo_nxt;
      OP_REMU: w_final = w_rem_nxt;
      default: w_final = w_mul_acc;
    endcase
  end
`else
  assign w_is_iter = (aluop_i == OP_MUL);
  assign w_final   = w_mul_acc;
`endif

  assign w_mul_acc   = r_acc + (r_b[0] ? r_a : '0);
  assign w_load_iter = w_out_free && ((r_state == S_BUSY && w_last) || r_state == S_WAIT);
  assign w_iter_data = (r_state == S_WAIT) ? r_res : w_final;

  always_comb begin
    w_alu = '0;
    case (aluop_i)
      OP_ADD:  w_alu = reg0_i + reg1_i;
      OP_SUB:  w_alu = reg0_i - reg1_i;
      OP_AND:  w_alu = reg0_i & reg1_i;
      OP_OR:   w_alu = reg0_i | reg1_i;
      OP_XOR:  w_alu = reg0_i ^ reg1_i;
      OP_NOT:  w_alu = ~reg0_i;
      OP_SLL:  w_alu = reg0_i << w_sh;
      OP_SRL:  w_alu = reg0_i >> w_sh;
      OP_SRA:  w_alu = $signed(reg0_i) >>> w_sh;
      OP_SLT:  w_alu = DATA_W'($signed(reg0_i) < $signed(reg1_i));
      OP_DIVU, OP_REMU: w_alu = '0;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_iter) w_state_nxt = S_BUSY;
      S_BUSY: if (w_last) w_state_nxt = w_out_free ? S_IDLE : S_WAIT;
      S_WAIT: if (w_out_free) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_waddr <= '0;
      r_we    <= 1'b0;
`ifdef EX_DIV_EN
      r_op    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && w_is_iter) begin
        r_a     <= reg0_i;
        r_b     <= reg1_i;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_waddr <= waddr_i;
        r_we    <= we_i;
`ifdef EX_DIV_EN
        r_op    <= aluop_i;
`endif
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + SH_W'(1);
`ifdef EX_DIV_EN
        if (r_op == OP_MUL) begin
          r_acc <= w_mul_acc;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
        end else begin
          r_acc <= w_rem_nxt;
          r_a   <= w_quo_nxt;
        end
`else
        r_acc <= w_mul_acc;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
`endif
        // Park the finished value when the output register is still blocked.
        if (w_last && !w_out_free) r_res <= w_final;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (w_accept && !w_is_iter) begin
      valid_o <= 1'b1;
      wdata_o <= w_alu;
      waddr_o <= waddr_i;
      we_o    <= we_i;
    end else if (w_load_iter) begin
      valid_o <= 1'b1;
      wdata_o <= w_iter_data;
      waddr_o <= r_waddr;
      we_o    <= r_we;
    end else if (!stall_i) begin
      valid_o <= 1'b0;
      we_o    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_iter.sv
// Self-checking bench for ex_iter: vector table through a scoreboard plus hand-written multi-cycle sequences.
module tb_ex_iter;
  localparam int DW = 16, AW = 4, OW = 4;
`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
    logic          we;
  } res_t;

  logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0, stall_i = 1'b0, we_i = 1'b0;
  logic [OW-1:0] aluop_i = '0;
  logic [DW-1:0] reg0_i = '0, reg1_i = '0;
  logic [AW-1:0] waddr_i = '0;
  logic ready_o, valid_o, we_o, busy_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;

  int checks = 0, failures = 0;
  res_t sb[$];
  vec_t vecs[$];
  bit rnd_stall = 1'b0;

  ex_iter #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .aluop_i(aluop_i),
    .reg0_i(reg0_i), .reg1_i(reg1_i), .waddr_i(waddr_i), .we_i(we_i),
    .valid_o(valid_o), .stall_i(stall_i), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .we_o(we_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change at negedge+1; sampling at negedge+3 sees exactly what the next posedge will use.
  always @(negedge clk) begin
    res_t e;
    #3;
    if (!rst) begin
      if (!valid_o) begin
        checks++;
        if (we_o !== 1'b0) begin
          failures++;
          $display("FAIL we_when_invalid actual=%b required=0", we_o);
        end
      end
      if (valid_o && !stall_i) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result actual=%h/%h required=none", waddr_o, wdata_o);
        end else begin
          e = sb.pop_front();
          if ({waddr_o, wdata_o, we_o} !== e) begin
            failures++;
            $display("FAIL result actual=wa%h d%h we%b required=wa%h d%h we%b",
                     waddr_o, wdata_o, we_o, e.wa, e.d, e.we);
          end
        end
      end
    end
  end

  task automatic issue(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [AW-1:0] wa, input logic we, input logic [DW-1:0] exp);
    @(negedge clk); #1;
    aluop_i = op; reg0_i = a; reg1_i = b; waddr_i = wa; we_i = we; valid_i = 1'b1;
    if (rnd_stall) stall_i = 1'($urandom_range(0, 1));
    #1;
    for (int t = 0; t < 100; t++) begin
      if (ready_o) begin
        sb.push_back('{wa: wa, d: exp, we: we});
        @(posedge clk); #1;
        valid_i = 1'b0;
        return;
      end
      @(negedge clk); #1;
      if (rnd_stall) stall_i = 1'($urandom_range(0, 1));
      #1;
    end
    checks++; failures++;
    $display("FAIL issue_timeout op=%0d actual_ready=0 required=1", op);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk); #1;
    stall_i = 1'b0;
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int lat;
    vecs.push_back('{4'd1,  16'hFFFF, 16'h0002, 16'h0001});
    vecs.push_back('{4'd2,  16'h0005, 16'h0007, 16'hFFFE});
    vecs.push_back('{4'd3,  16'hF0F0, 16'h3C3C, 16'h3030});
    vecs.push_back('{4'd4,  16'hF0F0, 16'h0F00, 16'hFFF0});
    vecs.push_back('{4'd5,  16'hAAAA, 16'hFFFF, 16'h5555});
    vecs.push_back('{4'd6,  16'h1234, 16'h0000, 16'hEDCB});
    vecs.push_back('{4'd7,  16'h0001, 16'h0014, 16'h0010});
    vecs.push_back('{4'd8,  16'h8000, 16'h0003, 16'h1000});
    vecs.push_back('{4'd9,  16'h8000, 16'h0013, 16'hF000});
    vecs.push_back('{4'd10, 16'hFFFF, 16'h0001, 16'h0001});
    vecs.push_back('{4'd10, 16'h0001, 16'hFFFF, 16'h0000});
    vecs.push_back('{4'd0,  16'h1234, 16'h5678, 16'h0000});
    vecs.push_back('{4'd14, 16'h1234, 16'h5678, 16'h0000});
    vecs.push_back('{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000});
    vecs.push_back('{4'd11, 16'h0012, 16'h0034, 16'h03A8});
    vecs.push_back('{4'd11, 16'hFFFF, 16'hFFFF, 16'h0001});
    vecs.push_back('{4'd11, 16'h1234, 16'h0003, 16'h369C});
    vecs.push_back('{4'd12, 16'd100,  16'd7,    DIV_EN ? 16'h000E : 16'h0000});
    vecs.push_back('{4'd13, 16'd100,  16'd7,    DIV_EN ? 16'h0002 : 16'h0000});
    vecs.push_back('{4'd12, 16'd5,    16'd0,    DIV_EN ? 16'hFFFF : 16'h0000});
    vecs.push_back('{4'd13, 16'd5,    16'd0,    DIV_EN ? 16'h0005 : 16'h0000});

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_waddr", waddr_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);

    // Table, back-to-back without stalls, then with random downstream stalls
    for (int p = 0; p < 2; p++) begin
      rnd_stall = (p == 1);
      for (int i = 0; i < vecs.size(); i++)
        issue(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i + 3 * p), (i % 3) != 0, vecs[i].exp);
      rnd_stall = 1'b0;
      drain();
    end

    // MUL with stall held across completion, then accept in the cycle stall drops
    @(negedge clk); #1;
    stall_i = 1'b1;
    aluop_i = 4'd11; reg0_i = 16'h0012; reg1_i = 16'h0034; waddr_i = 4'd5; we_i = 1'b1; valid_i = 1'b1;
    #1;
    chk("mul_accept_ready", ready_o, 1);
    sb.push_back('{wa: 4'd5, d: 16'h03A8, we: 1'b1});
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #2;
      chk($sformatf("mul_busy_c%0d", k), {busy_o, ready_o, valid_o}, 3'b100);
    end
    @(negedge clk); #2;
    chk("mul_done_c17", {valid_o, busy_o, wdata_o}, {1'b1, 1'b0, 16'h03A8});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      chk($sformatf("mul_hold_%0d", k), {valid_o, ready_o, we_o, waddr_o, wdata_o},
          {1'b1, 1'b0, 1'b1, 4'd5, 16'h03A8});
    end
    @(negedge clk); #1;
    stall_i = 1'b0;
    aluop_i = 4'd1; reg0_i = 16'h0003; reg1_i = 16'h0004; waddr_i = 4'd6; we_i = 1'b1; valid_i = 1'b1;
    #1;
    chk("unstall_ready", ready_o, 1);
    sb.push_back('{wa: 4'd6, d: 16'h0007, we: 1'b1});
    @(posedge clk); #1;
    valid_i = 1'b0;
    drain();

    // DIVU latency
    @(negedge clk); #1;
    aluop_i = 4'd12; reg0_i = 16'd100; reg1_i = 16'd7; waddr_i = 4'd2; we_i = 1'b0; valid_i = 1'b1;
    #1;
    sb.push_back('{wa: 4'd2, d: DIV_EN ? 16'h000E : 16'h0000, we: 1'b0});
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk); #2;
      if (valid_o) break;
      lat++;
    end
    chk("divu_latency", lat, DIV_EN ? 17 : 1);
    drain();

    // Reset in the middle of a MUL
    @(negedge clk); #1;
    aluop_i = 4'd11; reg0_i = 16'hFFFF; reg1_i = 16'hFFFF; waddr_i = 4'd9; we_i = 1'b1; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #2;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_ready", ready_o, 1);
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk); #2;
      chk($sformatf("midrst_no_stale_%0d", k), valid_o, 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
